// File: rtl/mm_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_ctrl_pkg : shared matrix-multiply defaults and controller state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package mm_ctrl_pkg;

  localparam int unsigned MM_N      = 8;
  localparam int unsigned MM_RD_LAT = 1;
  // Accumulator width of the MAC datapath: 8b x 8b products summed N times.
  localparam int unsigned MM_ACC_W  = 19;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_READ   = 3'd2,
    S_WAIT   = 3'd3,
    S_LOAD   = 3'd4,
    S_UNLOAD = 3'd5,
    S_DONE   = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mm_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_ctrl_if : start handshake plus memory/MAC/shift-chain control bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface mm_ctrl_if #(
  parameter int N = 8
) ();

  localparam int AW = $clog2(N * N);
  localparam int KW = $clog2(N);

  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] a_addr;
  logic [KW-1:0] b_addr;
  logic          mac_clr;
  logic          mac_en;
  logic          sr_load;
  logic          sr_shift;
  logic [AW-1:0] c_addr;
  logic          c_we;

  modport master (
    input  start,
    output busy, done, a_addr, b_addr, mac_clr, mac_en,
           sr_load, sr_shift, c_addr, c_we
  );

  modport slave (
    output start,
    input  busy, done, a_addr, b_addr, mac_clr, mac_en,
           sr_load, sr_shift, c_addr, c_we
  );

endinterface
`default_nettype wire

// File: rtl/vld_delay.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vld_delay : RD_LAT-deep valid shift line aligning mac_en with read data
// Rev 1.0
// ----------------------------------------------------------------------------
module vld_delay #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_in,
  output logic vld_out
);

  logic [RD_LAT-1:0] pipe_q;
  logic [RD_LAT-1:0] pipe_d;

  generate
    if (RD_LAT == 1) begin : g_single
      always_comb begin
        pipe_d = vld_in;
      end
    end else begin : g_multi
      always_comb begin
        pipe_d = {pipe_q[RD_LAT-2:0], vld_in};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign vld_out = pipe_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/mm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_ctrl : row-by-row sequencer for an N x N matrix multiply (control only)
// Rev 1.0
// ----------------------------------------------------------------------------
module mm_ctrl
  import mm_ctrl_pkg::*;
#(
  parameter int N      = MM_N,
  parameter int RD_LAT = MM_RD_LAT
) (
  input  logic       clk,
  input  logic       rst_n,
  mm_ctrl_if.master  bus
);

  localparam int KW = $clog2(N);
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [WW-1:0] W_LAST = WW'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] row_q,   row_d;
  logic [KW-1:0] k_q,     k_d;
  logic [KW-1:0] j_q,     j_d;
  logic [WW-1:0] wait_q,  wait_d;

  logic          rd_vld;
  logic          mac_en_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      k_q     <= '0;
      j_q     <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      j_q     <= j_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    j_d     = j_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          row_d   = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_READ;
        k_d     = '0;
      end
      S_READ: begin
        if (k_q == K_LAST) begin
          state_d = S_WAIT;
          wait_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      // Drain the read pipeline so the last mac_en lands on the final WAIT cycle.
      S_WAIT: begin
        if (wait_q == W_LAST) begin
          state_d = S_LOAD;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_UNLOAD;
        j_d     = '0;
      end
      S_UNLOAD: begin
        if (j_q == K_LAST) begin
          if (row_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_CLEAR;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_vld = (state_q == S_READ);

  vld_delay #(
    .RD_LAT (RD_LAT)
  ) u_vld_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_in  (rd_vld),
    .vld_out (mac_en_dly)
  );

  always_comb begin
    bus.busy     = (state_q != S_IDLE);
    bus.done     = (state_q == S_DONE);
    bus.mac_clr  = (state_q == S_CLEAR);
    bus.mac_en   = mac_en_dly;
    bus.sr_load  = (state_q == S_LOAD);
    bus.sr_shift = (state_q == S_UNLOAD);
    bus.c_we     = (state_q == S_UNLOAD);
    bus.a_addr   = '0;
    bus.b_addr   = '0;
    bus.c_addr   = '0;
    // N is a power of two, so row*N+col is a plain concatenation.
    if (state_q == S_READ) begin
      bus.a_addr = {row_q, k_q};
      bus.b_addr = k_q;
    end
    if (state_q == S_UNLOAD) begin
      bus.c_addr = {row_q, j_q};
    end
  end

endmodule
`default_nettype wire
